// File: rtl/bp_checkpoint_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_checkpoint_queue_pkg
// Brief    : Shared branch-prediction widths and the checkpoint entry type.
// Revision : 1.0 - initial release
// ============================================================================
package bp_checkpoint_queue_pkg;

    localparam int GSHARE_GHSR_WIDTH = 8;
    localparam int BP_CKPT_DEPTH     = 8;

    typedef struct packed {
        logic [31:0]                  pc;
        logic [GSHARE_GHSR_WIDTH-1:0] ghsr;
        logic                         pred;
    } bp_ckpt_t;

endpackage
`default_nettype wire

// File: rtl/bp_checkpoint_queue.sv
`default_nettype none
// ============================================================================
// Module   : bp_checkpoint_queue
// Brief    : In-order checkpoint FIFO between fetch and EXE; drives the gshare
//            EXE-side update bus and flushes younger entries on mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module bp_checkpoint_queue
    import bp_checkpoint_queue_pkg::*;
#(
    parameter int DEPTH = BP_CKPT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push0_valid,
    input  logic                         push1_valid,
    input  logic [31:0]                  push0_pc,
    input  logic [31:0]                  push1_pc,
    input  logic [GSHARE_GHSR_WIDTH-1:0] push0_ghsr,
    input  logic [GSHARE_GHSR_WIDTH-1:0] push1_ghsr,
    input  logic                         push0_pred,
    input  logic                         push1_pred,
    input  logic [GSHARE_GHSR_WIDTH-1:0] cur_ghsr,
    input  logic                         res_valid,
    input  logic                         res_tracked,
    input  logic                         res_taken,
    input  logic [31:0]                  res_pc,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic                         mispredict,
    output logic                         EXE_is_BJ,
    output logic                         EXE_update_GHSR,
    output logic                         EXE_branch_taken,
    output logic [31:0]                  EXE_branch_addr,
    output logic [GSHARE_GHSR_WIDTH-1:0] EXE_GHSR_restore,
    output logic                         err_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL_LEVEL = CNT_W'(DEPTH - 1);

    bp_ckpt_t                     mem_q [DEPTH];
    bp_ckpt_t                     mem_d [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_nxt;
    logic [CNT_W-1:0]             count_q, count_d, n_push, n_pop;
    logic                         err_q, err_d, mis_q, mis_d, bj_q, bj_d;
    logic                         upd_q, upd_d, taken_q, taken_d;
    logic [31:0]                  addr_q, addr_d;
    logic [GSHARE_GHSR_WIDTH-1:0] restore_q, restore_d;
    bp_ckpt_t                     head;
    logic                         pop, any_push, push_ok, flush_all;

    assign full  = (count_q >= C_FULL_LEVEL);
    assign empty = (count_q == '0);

    always_comb begin
        head      = mem_q[rd_ptr_q];
        pop       = res_valid && res_tracked && !empty;
        any_push  = push0_valid || push1_valid;
        bj_d      = res_valid;
        taken_d   = res_valid && res_taken;
        addr_d    = '0;
        restore_d = '0;
        mis_d     = 1'b0;
        // An untracked branch (or tracked with nothing queued) was implicitly predicted not-taken.
        if (pop) begin
            addr_d    = head.pc;
            restore_d = head.ghsr;
            mis_d     = (res_taken != head.pred);
        end else if (res_valid) begin
            addr_d    = res_pc;
            restore_d = cur_ghsr;
            mis_d     = res_taken;
        end
        upd_d = mis_d;

        err_d = err_q
              | (any_push && full)
              | (res_valid && res_tracked && empty)
              | (pop && (head.pc != res_pc));

        flush_all = mis_d || flush;
        push_ok   = any_push && !full && !flush_all;
        n_push    = push_ok ? (CNT_W'(push0_valid) + CNT_W'(push1_valid)) : '0;
        n_pop     = CNT_W'(pop);
        wr_nxt    = wr_ptr_q + 1'b1;

        mem_d = mem_q;
        if (push_ok) begin
            if (push0_valid) begin
                mem_d[wr_ptr_q] = '{pc: push0_pc, ghsr: push0_ghsr, pred: push0_pred};
            end
            if (push1_valid) begin
                mem_d[push0_valid ? wr_nxt : wr_ptr_q] =
                    '{pc: push1_pc, ghsr: push1_ghsr, pred: push1_pred};
            end
        end

        if (flush_all) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + n_push[PTR_W-1:0];
            rd_ptr_d = rd_ptr_q + n_pop[PTR_W-1:0];
            count_d  = count_q + n_push - n_pop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            bj_q      <= 1'b0;
            upd_q     <= 1'b0;
            taken_q   <= 1'b0;
            addr_q    <= '0;
            restore_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
            bj_q      <= bj_d;
            upd_q     <= upd_d;
            taken_q   <= taken_d;
            addr_q    <= addr_d;
            restore_q <= restore_d;
        end
    end

    assign mispredict       = mis_q;
    assign EXE_is_BJ        = bj_q;
    assign EXE_update_GHSR  = upd_q;
    assign EXE_branch_taken = taken_q;
    assign EXE_branch_addr  = addr_q;
    assign EXE_GHSR_restore = restore_q;
    assign err_sticky       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_checkpoint_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_checkpoint_queue
// Brief    : Directed and randomized bench for bp_checkpoint_queue with a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_checkpoint_queue;
    import bp_checkpoint_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int GW    = GSHARE_GHSR_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          push0_valid, push1_valid, push0_pred, push1_pred;
    logic [31:0]   push0_pc, push1_pc, res_pc;
    logic [GW-1:0] push0_ghsr, push1_ghsr, cur_ghsr;
    logic          res_valid, res_tracked, res_taken, flush;
    logic          full, empty, mispredict, EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken, err_sticky;
    logic [31:0]   EXE_branch_addr;
    logic [GW-1:0] EXE_GHSR_restore;

    int checks = 0;
    int errors = 0;

    bp_ckpt_t      mq[$];
    logic          e_bj, e_upd, e_tk, e_mp, e_err;
    logic [31:0]   e_addr;
    logic [GW-1:0] e_rst;

    bp_checkpoint_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .push0_valid(push0_valid), .push1_valid(push1_valid),
        .push0_pc(push0_pc), .push1_pc(push1_pc),
        .push0_ghsr(push0_ghsr), .push1_ghsr(push1_ghsr),
        .push0_pred(push0_pred), .push1_pred(push1_pred),
        .cur_ghsr(cur_ghsr), .res_valid(res_valid), .res_tracked(res_tracked),
        .res_taken(res_taken), .res_pc(res_pc), .flush(flush),
        .full(full), .empty(empty), .mispredict(mispredict),
        .EXE_is_BJ(EXE_is_BJ), .EXE_update_GHSR(EXE_update_GHSR),
        .EXE_branch_taken(EXE_branch_taken), .EXE_branch_addr(EXE_branch_addr),
        .EXE_GHSR_restore(EXE_GHSR_restore), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic idle();
        push0_valid = 0; push1_valid = 0; push0_pred = 0; push1_pred = 0;
        push0_pc = '0; push1_pc = '0; push0_ghsr = '0; push1_ghsr = '0;
        cur_ghsr = '0; res_valid = 0; res_tracked = 0; res_taken = 0;
        res_pc = '0; flush = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        {e_bj, e_upd, e_tk, e_mp, e_err} = '0;
        e_addr = '0;
        e_rst  = '0;
    endtask

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_cycle();
        bp_ckpt_t h;
        logic     pfull, mp;
        pfull = (mq.size() >= DEPTH - 1);
        mp    = 1'b0;
        e_bj = 0; e_tk = 0; e_addr = '0; e_rst = '0;
        if (res_valid) begin
            e_bj = 1; e_tk = res_taken;
            if (res_tracked && mq.size() != 0) begin
                h = mq.pop_front();
                if (h.pc != res_pc) e_err = 1;
                mp = (res_taken != h.pred); e_addr = h.pc; e_rst = h.ghsr;
            end else begin
                if (res_tracked) e_err = 1;
                mp = res_taken; e_addr = res_pc; e_rst = cur_ghsr;
            end
        end
        e_upd = mp; e_mp = mp;
        if ((push0_valid || push1_valid) && pfull) e_err = 1;
        if (mp || flush) mq.delete();
        else if (!pfull) begin
            if (push0_valid) mq.push_back('{pc: push0_pc, ghsr: push0_ghsr, pred: push0_pred});
            if (push1_valid) mq.push_back('{pc: push1_pc, ghsr: push1_ghsr, pred: push1_pred});
        end
    endtask

    task automatic run_cycle();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_cycle();
        idle(); flush = 1; run_cycle(); idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1; model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken, EXE_branch_addr, EXE_GHSR_restore} !== '0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0",
                {EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken, EXE_branch_addr, EXE_GHSR_restore});
        end
        checks++;
        if ({full, empty, err_sticky, mispredict} !== 4'b0100) begin
            errors++; $display("FAIL reset_status: got %b expected 0100", {full, empty, err_sticky, mispredict});
        end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        idle(); push0_valid = 1; push0_pc = 32'h100; push0_ghsr = 8'h05; push0_pred = 1;
        run_cycle();
        idle(); res_valid = 1; res_tracked = 1; res_taken = 1; res_pc = 32'h100;
        run_cycle(); idle();
        checks++;
        if ({EXE_is_BJ, EXE_update_GHSR, mispredict, EXE_GHSR_restore, EXE_branch_addr, empty}
            !== {1'b1, 1'b0, 1'b0, 8'h05, 32'h100, 1'b1}) begin
            errors++; $display("FAIL single_resolve: got bj=%b upd=%b mp=%b rst=%h addr=%h empty=%b expected 1 0 0 05 00000100 1",
                EXE_is_BJ, EXE_update_GHSR, mispredict, EXE_GHSR_restore, EXE_branch_addr, empty);
        end
    endtask

    task automatic test_mispredict();
        idle();
        push0_valid = 1; push0_pc = 32'h200; push0_ghsr = 8'h11; push0_pred = 0;
        push1_valid = 1; push1_pc = 32'h204; push1_ghsr = 8'h22; push1_pred = 1;
        run_cycle();
        idle(); res_valid = 1; res_tracked = 1; res_taken = 1; res_pc = 32'h200;
        push0_valid = 1; push0_pc = 32'h208; push0_ghsr = 8'h33;
        run_cycle(); idle();
        checks++;
        if ({mispredict, EXE_update_GHSR, EXE_branch_taken, EXE_GHSR_restore, EXE_branch_addr, empty, err_sticky}
            !== {1'b1, 1'b1, 1'b1, 8'h11, 32'h200, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mispredict_flush: got mp=%b upd=%b tk=%b rst=%h addr=%h empty=%b err=%b expected 1 1 1 11 00000200 1 0",
                mispredict, EXE_update_GHSR, EXE_branch_taken, EXE_GHSR_restore, EXE_branch_addr, empty, err_sticky);
        end
        run_cycle();
        checks++;
        if ({mispredict, EXE_is_BJ, empty} !== 3'b001) begin
            errors++; $display("FAIL mispredict_pulse: got mp/bj/empty=%b expected 001", {mispredict, EXE_is_BJ, empty});
        end
    endtask

    task automatic test_untracked();
        idle(); res_valid = 1; res_taken = 1; res_pc = 32'h300; cur_ghsr = 8'h1A;
        run_cycle(); idle();
        checks++;
        if ({EXE_is_BJ, EXE_update_GHSR, mispredict, EXE_GHSR_restore, EXE_branch_addr}
            !== {1'b1, 1'b1, 1'b1, 8'h1A, 32'h300}) begin
            errors++; $display("FAIL untracked_taken: got bj=%b upd=%b mp=%b rst=%h addr=%h expected 1 1 1 1a 00000300",
                EXE_is_BJ, EXE_update_GHSR, mispredict, EXE_GHSR_restore, EXE_branch_addr);
        end
        push0_valid = 1; push0_pc = 32'h280; push0_ghsr = 8'h44; push0_pred = 0;
        run_cycle();
        idle(); res_valid = 1; res_pc = 32'h284; cur_ghsr = 8'h55;
        run_cycle(); idle();
        checks++;
        if ({EXE_is_BJ, EXE_update_GHSR, mispredict, EXE_GHSR_restore, empty} !== {3'b100, 8'h55, 1'b0}) begin
            errors++; $display("FAIL untracked_nopop: got bj=%b upd=%b mp=%b rst=%h empty=%b expected 1 0 0 55 0",
                EXE_is_BJ, EXE_update_GHSR, mispredict, EXE_GHSR_restore, empty);
        end
        res_valid = 1; res_tracked = 1; res_pc = 32'h280;
        run_cycle(); idle();
        checks++;
        if ({EXE_branch_addr, EXE_GHSR_restore, empty, err_sticky} !== {32'h280, 8'h44, 1'b1, 1'b0}) begin
            errors++; $display("FAIL untracked_head_kept: got addr=%h rst=%h empty=%b err=%b expected 00000280 44 1 0",
                EXE_branch_addr, EXE_GHSR_restore, empty, err_sticky);
        end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        logic popping;
        flush_cycle();
        for (int blk = 0; blk < 3; blk++) begin
            for (int r = 0; r < 3 + 6; r++) begin
                idle();
                if (r < 3) begin
                    push0_valid = 1; push0_pc = 32'h400 + 32'(4 * pushed); push0_pred = pushed[0];
                    push0_ghsr = GW'(pushed);
                    push1_valid = 1; push1_pc = 32'h400 + 32'(4 * (pushed + 1)); push1_pred = ~pushed[0];
                    push1_ghsr = GW'(pushed + 1);
                    pushed += 2;
                end
                popping = (mq.size() != 0);
                if (popping) begin
                    res_valid = 1; res_tracked = 1;
                    res_pc = 32'h400 + 32'(4 * popped); res_taken = popped[0];
                end
                run_cycle();
                if (popping) begin
                    checks++;
                    if ({EXE_branch_addr, mispredict} !== {32'h400 + 32'(4 * popped), 1'b0}) begin
                        errors++; $display("FAIL wrap_order pop %0d: got addr=%h mp=%b expected %h 0",
                            popped, EXE_branch_addr, mispredict, 32'h400 + 32'(4 * popped));
                    end
                    popped++;
                end
            end
        end
        idle();
        checks++;
        if ({empty, err_sticky, 32'(popped)} !== {1'b1, 1'b0, 32'(pushed)}) begin
            errors++; $display("FAIL wrap_drain: got empty=%b err=%b pops=%0d expected 1 0 %0d", empty, err_sticky, popped, pushed);
        end
    endtask

    task automatic test_random();
        int r;
        flush_cycle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            if (mq.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) begin
                push0_valid = 1'($urandom_range(0, 1)); push1_valid = 1'($urandom_range(0, 1));
                push0_pc = $urandom() & 32'hFFFF_FFFC; push1_pc = $urandom() & 32'hFFFF_FFFC;
                push0_ghsr = GW'($urandom()); push1_ghsr = GW'($urandom());
                push0_pred = 1'($urandom_range(0, 1)); push1_pred = 1'($urandom_range(0, 1));
            end
            r = $urandom_range(0, 9);
            cur_ghsr = GW'($urandom());
            if (r < 5 && mq.size() != 0) begin
                res_valid = 1; res_tracked = 1; res_pc = mq[0].pc;
                res_taken = ($urandom_range(0, 5) == 0) ? ~mq[0].pred : mq[0].pred;
            end else if (r < 7 && mq.size() == 0) begin
                res_valid = 1; res_taken = 1'($urandom_range(0, 1)); res_pc = $urandom() & 32'hFFFF_FFFC;
            end else if (r == 7) begin
                res_valid = 1; res_pc = $urandom() & 32'hFFFF_FFFC;
            end
            flush = ($urandom_range(0, 40) == 0);
            run_cycle();
            checks++;
            if ({EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken, EXE_branch_addr, EXE_GHSR_restore, mispredict}
                !== {e_bj, e_upd, e_tk, e_addr, e_rst, e_mp}) begin
                errors++; $display("FAIL rand_bus cycle %0d: got %h expected %h", cyc,
                    {EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken, EXE_branch_addr, EXE_GHSR_restore, mispredict},
                    {e_bj, e_upd, e_tk, e_addr, e_rst, e_mp});
            end
            checks++;
            if ({full, empty, err_sticky} !== {mq.size() >= DEPTH - 1, mq.size() == 0, e_err}) begin
                errors++; $display("FAIL rand_status cycle %0d: got full/empty/err=%b expected %b", cyc,
                    {full, empty, err_sticky}, {mq.size() >= DEPTH - 1, mq.size() == 0, e_err});
            end
        end
        idle();
    endtask

    task automatic test_full();
        flush_cycle();
        for (int i = 0; i < DEPTH - 1; i++) begin
            idle(); push0_valid = 1; push0_pc = 32'h800 + 32'(4 * i); push0_pred = 0;
            run_cycle();
        end
        idle();
        checks++;
        if ({full, empty, err_sticky} !== 3'b100) begin
            errors++; $display("FAIL full_level: got full/empty/err=%b expected 100", {full, empty, err_sticky});
        end
        push0_valid = 1; push1_valid = 1; push0_pc = 32'hBAD0; push1_pc = 32'hBAD4;
        run_cycle(); idle();
        checks++;
        if ({full, err_sticky} !== 2'b11) begin
            errors++; $display("FAIL full_push_err: got full/err=%b expected 11", {full, err_sticky});
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            res_valid = 1; res_tracked = 1; res_pc = 32'h800 + 32'(4 * i);
            run_cycle();
            checks++;
            if ({EXE_branch_addr, empty} !== {32'h800 + 32'(4 * i), 1'(i == DEPTH - 2)}) begin
                errors++; $display("FAIL full_drain pop %0d: got addr=%h empty=%b expected %h %b",
                    i, EXE_branch_addr, empty, 32'h800 + 32'(4 * i), 1'(i == DEPTH - 2));
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        flush_cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); push0_valid = 1; push1_valid = 1;
            push0_pc = 32'hC00 + 32'(8 * i); push1_pc = 32'hC04 + 32'(8 * i);
            run_cycle();
        end
        idle(); res_valid = 1; res_tracked = 1; res_pc = 32'hC00;
        run_cycle(); idle();
        checks++;
        if ({EXE_is_BJ, empty} !== 2'b10) begin
            errors++; $display("FAIL async_pre: got bj/empty=%b expected 10", {EXE_is_BJ, empty});
        end
        #2 reset = 1;
        #1;
        model_reset();
        checks++;
        if ({EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken, EXE_branch_addr, EXE_GHSR_restore,
             mispredict, err_sticky, full, empty} !== {44'h0, 1'b1}) begin
            errors++; $display("FAIL async_reset: got %h expected 1",
                {EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken, EXE_branch_addr, EXE_GHSR_restore,
                 mispredict, err_sticky, full, empty});
        end
        #2 reset = 0;
        @(posedge clk); #1;
        push0_valid = 1; push0_pc = 32'hD00;
        run_cycle(); idle();
        res_valid = 1; res_tracked = 1; res_pc = 32'hD00;
        run_cycle(); idle();
        checks++;
        if ({EXE_branch_addr, empty, err_sticky} !== {32'hD00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL async_after: got addr=%h empty=%b err=%b expected 00000d00 1 0",
                EXE_branch_addr, empty, err_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mispredict();
        test_untracked();
        test_wrap();
        test_random();
        test_full();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_checkpoint_queue.md
# bp_checkpoint_queue

In-order FIFO of branch-prediction checkpoints between fetch and execute. Each cycle, fetch pushes up to two entries for BTB-hit branches: PC, gshare GHSR snapshot and predicted direction. When a branch resolves in EXE, the block pops the oldest entry and compares the prediction with the outcome. It then drives the gshare EXE-side update bus (`EXE_is_BJ`, `EXE_update_GHSR`, `EXE_branch_taken`, `EXE_branch_addr`, `EXE_GHSR_restore`) one cycle later, and flushes all younger checkpoints on a mispredict.

## Interface
Parameters:
- `DEPTH`, 8 — entries; power of two, ≥ 4.
- `GSHARE_GHSR_WIDTH` — taken from the common package.

Ports:
- `clk` in 1 — single clock; all state on rising edge.
- `reset` in 1 — asynchronous, active-high.
- `push0_valid`, `push1_valid` in 1 each — slot 0/1 pushes a checkpoint. Slot 0 is older. `push1_valid` without `push0_valid` is legal.
- `push0_pc`, `push1_pc` in 32 — branch PCs.
- `push0_ghsr`, `push1_ghsr` in GSHARE_GHSR_WIDTH — from gshare `current_instr0/1_GHSR`.
- `push0_pred`, `push1_pred` in 1 — predicted taken.
- `cur_ghsr` in GSHARE_GHSR_WIDTH — live speculative GHSR; used only for untracked branches.
- `res_valid` in 1 — a branch or jump resolves in EXE this cycle.
- `res_tracked` in 1 — the resolving branch had a BTB hit, so it owns the head entry.
- `res_taken` in 1 — actual direction.
- `res_pc` in 32 — resolving PC.
- `flush` in 1 — external pipeline flush (e.g. exception).
- `full` out 1 — fewer than 2 free entries; fetch must not push.
- `empty` out 1 — count == 0.
- `mispredict` out 1 — registered; redirect front end.
- `EXE_is_BJ`, `EXE_update_GHSR`, `EXE_branch_taken` out 1 — registered gshare update bus.
- `EXE_branch_addr` out 32 — registered gshare update bus.
- `EXE_GHSR_restore` out GSHARE_GHSR_WIDTH — registered gshare update bus.
- `err_sticky` out 1 — sticky protocol error: push when full, tracked resolve when empty, or head-PC mismatch.

## Operation
Storage:
- Circular buffer with `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits. Both wrap modulo DEPTH.
- `count` is $clog2(DEPTH)+1 bits.

Push:
- Valid slots are written in order at `wr_ptr` and `wr_ptr+1`.
- `wr_ptr` advances by the number of valid slots.
- A push while `full` is dropped and sets `err_sticky`.

Tracked resolve (`res_valid && res_tracked`):
- Pop the head entry.
- If `head.pc != res_pc`, set `err_sticky` but still pop.
- `mis = res_taken != head.pred`.
- Outputs next cycle: `EXE_is_BJ=1`, `EXE_branch_taken=res_taken`, `EXE_branch_addr=head.pc`, `EXE_GHSR_restore=head.ghsr`, `EXE_update_GHSR=mis`, `mispredict=mis`.
- A tracked resolve while empty makes no state change except `err_sticky`. Outputs are driven as for untracked.

Untracked resolve (`res_valid && !res_tracked`):
- No pop. The implicit prediction was not-taken.
- Outputs next cycle: `EXE_is_BJ=1`, `EXE_branch_addr=res_pc`, `EXE_GHSR_restore=cur_ghsr`, `EXE_update_GHSR=res_taken`, `mispredict=res_taken`.

Flush:
- Condition: a mispredict (as computed above) or `flush`.
- Effect: `rd_ptr=wr_ptr=0`, `count=0`.
- Pushes in the same cycle are dropped without error.
- The pop of the resolving entry still produces its update bus.

Simultaneous events:
- Push and pop in one cycle: `count += pushes − pops`.
- A pop frees space for a same-cycle push only in the next cycle, because `full` is computed from the registered `count`.

## Timing
Reset values:
- `count=0`, pointers 0, `empty=1`, `full=0`.
- All EXE_* outputs, `mispredict` and `err_sticky` are 0.
- Reset asserted mid-operation clears every entry immediately.

Latency:
- Resolve in cycle N → EXE_* bus and `mispredict` valid in cycle N+1 only, as a single-cycle pulse.
- Queue state after flush is empty in cycle N+1.
- `full` and `empty` are combinational from registered `count`, with no input-to-output paths.

Pointer wrap:
- With `wr_ptr=DEPTH−1`, a dual push writes slots DEPTH−1 and 0.

## Structure
- Common package additions: `GSHARE_GHSR_WIDTH` (existing), `BP_CKPT_DEPTH`, and a packed typedef `bp_ckpt_t {pc[31:0], ghsr, pred}`.
- The entry array uses `bp_ckpt_t`.
- No sub-module is required. The compare/output register stage is inline.

## Test plan
- Reset, then push0 (pc 0x100, ghsr 0x05, pred 1). Resolve tracked, taken, pc 0x100 → next cycle `EXE_is_BJ=1`, `EXE_update_GHSR=0`, `EXE_GHSR_restore=0x05`, `EXE_branch_addr=0x100`, `empty=1`.
- Dual push: pcs 0x200 (pred 0) and 0x204 (pred 1). Resolve 0x200 as taken → `mispredict=1`, `EXE_update_GHSR=1`, `EXE_branch_taken=1`, restore = 0x200's ghsr. Queue empty next cycle, and a push in the flush cycle is dropped.
- Untracked resolve, taken, pc 0x300, `cur_ghsr=0x1A` → `EXE_update_GHSR=1`, `EXE_GHSR_restore=0x1A`, `mispredict=1`, no pop.
- Fill to DEPTH−1 → `full=1`. Push anyway → `err_sticky=1`, count unchanged.
- Wrap: 3 rounds of dual push plus single pops with DEPTH=8 → FIFO order preserved across the ptr 7→0 boundary, and every `EXE_branch_addr` matches its push order.
- Assert `reset` asynchronously between clock edges with 5 entries → all outputs 0 and `empty=1` before the next edge.
